// File: rtl/sha1_block_core_if.sv
// Block-level handshake between a SHA-1 message framer and the compression core.
// The core sits on the slave side; the framer drives the master side.
interface sha1_block_core_if;
   logic         init;
   logic         next;
   logic [511:0] block;
   logic         ready;
   logic [159:0] digest;
   logic         digest_valid;

   modport master (
      output init, next, block,
      input  ready, digest, digest_valid
   );

   modport slave (
      input  init, next, block,
      output ready, digest, digest_valid
   );
endinterface

// File: rtl/sha1_block_core.sv
// SHA-1 compression of one pre-padded 512-bit block, one round per clock,
// accumulating the chaining value across init/next blocks.
module sha1_block_core (
   input  logic             clk,
   input  logic             reset_n,
   sha1_block_core_if.slave bus
);
   localparam logic [31:0] IV0 = 32'h67452301;
   localparam logic [31:0] IV1 = 32'hEFCDAB89;
   localparam logic [31:0] IV2 = 32'h98BADCFE;
   localparam logic [31:0] IV3 = 32'h10325476;
   localparam logic [31:0] IV4 = 32'hC3D2E1F0;

   typedef enum logic [1:0] {IDLE, ROUNDS, DONE} sha1_ctrl_t;

   sha1_ctrl_t        sha1_ctrl_reg, sha1_ctrl_new;
   logic [31:0]       H0_reg, H1_reg, H2_reg, H3_reg, H4_reg;
   logic [31:0]       a_reg, b_reg, c_reg, d_reg, e_reg;
   logic [31:0]       a_new, b_new, c_new, d_new, e_new;
   logic [6:0]        round_ctr_reg;
   logic [15:0][31:0] w_reg, w_load, w_shift;
   logic [31:0]       w;
   logic              digest_valid_reg;

   logic digest_init, digest_update, state_init, state_update;
   logic w_init, round_ctr_inc, round_ctr_rst, first_block, ready_flag;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
      rotl = (x << n) | (x >> (32 - n));
   endfunction

   // w_reg[i] holds W_{t+i}; block word 0 is the most significant 32 bits.
   always_comb begin
      w_load = '0;
      for (int i = 0; i < 16; i++)
         w_load[i] = bus.block[511 - 32*i -: 32];
   end

   always_comb begin
      w_shift = '0;
      for (int i = 0; i < 15; i++)
         w_shift[i] = w_reg[i+1];
      w_shift[15] = rotl(w_reg[13] ^ w_reg[8] ^ w_reg[2] ^ w_reg[0], 1);
   end

   always_comb begin : state_logic
      logic [31:0] f, k, t;
      f     = 32'h0;
      k     = 32'h0;
      w     = w_reg[0];
      a_new = a_reg;
      b_new = b_reg;
      c_new = c_reg;
      d_new = d_reg;
      e_new = e_reg;
      if (round_ctr_reg < 7'd20) begin
         f = (b_reg & c_reg) | (~b_reg & d_reg);
         k = 32'h5A827999;
      end else if (round_ctr_reg < 7'd40) begin
         f = b_reg ^ c_reg ^ d_reg;
         k = 32'h6ED9EBA1;
      end else if (round_ctr_reg < 7'd60) begin
         f = (b_reg & c_reg) | (b_reg & d_reg) | (c_reg & d_reg);
         k = 32'h8F1BBCDC;
      end else begin
         f = b_reg ^ c_reg ^ d_reg;
         k = 32'hCA62C1D6;
      end
      t = rotl(a_reg, 5) + f + e_reg + k + w;
      if (state_init) begin
         a_new = first_block ? IV0 : H0_reg;
         b_new = first_block ? IV1 : H1_reg;
         c_new = first_block ? IV2 : H2_reg;
         d_new = first_block ? IV3 : H3_reg;
         e_new = first_block ? IV4 : H4_reg;
      end else if (state_update) begin
         a_new = t;
         b_new = a_reg;
         c_new = rotl(b_reg, 30);
         d_new = c_reg;
         e_new = d_reg;
      end
   end

   always_comb begin : ctrl_logic
      sha1_ctrl_new = sha1_ctrl_reg;
      digest_init   = 1'b0;
      digest_update = 1'b0;
      state_init    = 1'b0;
      state_update  = 1'b0;
      w_init        = 1'b0;
      round_ctr_inc = 1'b0;
      round_ctr_rst = 1'b0;
      first_block   = 1'b0;
      ready_flag    = 1'b0;
      case (sha1_ctrl_reg)
         IDLE: begin
            ready_flag = 1'b1;
            if (bus.init || bus.next) begin
               first_block   = bus.init;
               digest_init   = bus.init;
               state_init    = 1'b1;
               w_init        = 1'b1;
               round_ctr_rst = 1'b1;
               sha1_ctrl_new = ROUNDS;
            end
         end
         ROUNDS: begin
            state_update  = 1'b1;
            round_ctr_inc = 1'b1;
            if (round_ctr_reg == 7'd79)
               sha1_ctrl_new = DONE;
         end
         DONE: begin
            digest_update = 1'b1;
            sha1_ctrl_new = IDLE;
         end
         default: sha1_ctrl_new = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sha1_ctrl_reg    <= IDLE;
         round_ctr_reg    <= 7'd0;
         digest_valid_reg <= 1'b0;
      end else begin
         sha1_ctrl_reg <= sha1_ctrl_new;
         if (round_ctr_rst)
            round_ctr_reg <= 7'd0;
         else if (round_ctr_inc)
            round_ctr_reg <= round_ctr_reg + 7'd1;
         if (state_init)
            digest_valid_reg <= 1'b0;
         else if (digest_update)
            digest_valid_reg <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_reg <= '0; b_reg <= '0; c_reg <= '0; d_reg <= '0; e_reg <= '0;
         w_reg <= '0;
      end else begin
         a_reg <= a_new; b_reg <= b_new; c_reg <= c_new; d_reg <= d_new; e_reg <= e_new;
         if (w_init)
            w_reg <= w_load;
         else if (state_update)
            w_reg <= w_shift;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         H0_reg <= '0; H1_reg <= '0; H2_reg <= '0; H3_reg <= '0; H4_reg <= '0;
      end else if (digest_init) begin
         H0_reg <= IV0; H1_reg <= IV1; H2_reg <= IV2; H3_reg <= IV3; H4_reg <= IV4;
      end else if (digest_update) begin
         H0_reg <= H0_reg + a_reg;
         H1_reg <= H1_reg + b_reg;
         H2_reg <= H2_reg + c_reg;
         H3_reg <= H3_reg + d_reg;
         H4_reg <= H4_reg + e_reg;
      end
   end

   assign bus.ready        = ready_flag;
   assign bus.digest       = {H0_reg, H1_reg, H2_reg, H3_reg, H4_reg};
   assign bus.digest_valid = digest_valid_reg;
endmodule

// File: tb/tb_sha1_block_core.sv
// Directed known-answer vectors for sha1_block_core, including protocol
// abuse during ROUNDS and a mid-block reset.
module tb_sha1_block_core;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   sha1_block_core_if bus ();

   sha1_block_core dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   localparam logic [159:0] IV_DIG  = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;
   localparam logic [511:0] FOX_BLK = 512'h746865717569636B62726F776E666F786A756D70736F7665727468656C617A79646F67746865717569636B62726F776E666F786A756D708000000000000001B8;
   localparam logic [159:0] FOX_DIG = 160'h58141f4f10dda66ff7efdf84217399e5ab6b963b;
   localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [159:0] ABC_DIG = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
   localparam logic [511:0] TWO_B1  = 512'h6162636462636465636465666465666765666768666768696768696A68696A6B696A6B6C6A6B6C6D6B6C6D6E6C6D6E6F6D6E6F706E6F70718000000000000000;
   localparam logic [159:0] TWO_D1  = 160'hf4286818c37b27ae0408f581846771484a566572;
   localparam logic [511:0] TWO_B2  = {480'h0, 32'h000001C0};
   localparam logic [159:0] TWO_D2  = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] rnd_block();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   // Launch one block, scramble block afterwards, count cycles until ready.
   task automatic run(input string tag, input logic i, input logic n,
                      input logic [511:0] b, input logic [159:0] exp);
      int cnt;
      @(negedge clk);
      bus.init = i; bus.next = n; bus.block = b;
      @(posedge clk); #1;
      bus.init = 1'b0; bus.next = 1'b0; bus.block = rnd_block();
      chk({tag, "_busy"}, {159'h0, bus.ready}, 160'h0);
      chk({tag, "_dv_clr"}, {159'h0, bus.digest_valid}, 160'h0);
      if (i) chk({tag, "_iv"}, bus.digest, IV_DIG);
      cnt = 0;
      while (bus.ready !== 1'b1 && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk({tag, "_latency"}, 160'(cnt), 160'd81);
      chk({tag, "_digest"}, bus.digest, exp);
      chk({tag, "_dv"}, {159'h0, bus.digest_valid}, 160'h1);
   endtask

   initial begin
      int cnt;
      bus.init = 1'b0; bus.next = 1'b0; bus.block = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {159'h0, bus.ready}, 160'h1);
      chk("rst_dv", {159'h0, bus.digest_valid}, 160'h0);
      chk("rst_digest", bus.digest, 160'h0);
      @(negedge clk); reset_n = 1'b1;

      run("fox", 1'b1, 1'b0, FOX_BLK, FOX_DIG);
      run("abc", 1'b1, 1'b0, ABC_BLK, ABC_DIG);
      run("two1", 1'b1, 1'b0, TWO_B1, TWO_D1);
      run("two2", 1'b0, 1'b1, TWO_B2, TWO_D2);
      // init must win over next while H holds a non-IV chaining value
      run("both", 1'b1, 1'b1, ABC_BLK, ABC_DIG);

      // init/next pulses and block changes during ROUNDS must be ignored
      @(negedge clk);
      bus.init = 1'b1; bus.block = ABC_BLK;
      @(posedge clk); #1;
      bus.init = 1'b0;
      cnt = 0;
      while (bus.ready !== 1'b1 && cnt < 200) begin
         @(negedge clk);
         bus.next  = (cnt == 10) || (cnt == 79);
         bus.init  = (cnt >= 30 && cnt < 33);
         bus.block = rnd_block();
         @(posedge clk); #1;
         cnt++;
      end
      bus.init = 1'b0; bus.next = 1'b0;
      chk("intr_latency", 160'(cnt), 160'd81);
      chk("intr_digest", bus.digest, ABC_DIG);
      repeat (5) @(posedge clk);
      #1;
      chk("intr_no_extra_ready", {159'h0, bus.ready}, 160'h1);
      chk("intr_no_extra_dv", {159'h0, bus.digest_valid}, 160'h1);
      chk("intr_hold_digest", bus.digest, ABC_DIG);

      // reset around round 40 aborts immediately
      @(negedge clk);
      bus.init = 1'b1; bus.block = FOX_BLK;
      @(posedge clk); #1;
      bus.init = 1'b0;
      repeat (40) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_ready", {159'h0, bus.ready}, 160'h1);
      chk("arst_dv", {159'h0, bus.digest_valid}, 160'h0);
      chk("arst_digest", bus.digest, 160'h0);
      @(negedge clk); reset_n = 1'b1;
      run("post_rst_abc", 1'b1, 1'b0, ABC_BLK, ABC_DIG);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sha1_block_core.md
Name: sha1_block_core

Overview:
- Single-block SHA-1 compression engine (FIPS 180-4).
- Takes one pre-padded 512-bit block and performs the 80-round compression at one round per clock.
- Accumulates the 160-bit chaining value, so multi-block messages are processed with init followed by repeated next.
- Leaf datapath block; padding and message framing are done upstream.

Parameters:
- None.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- init  input  1  start hashing a new message with this block; H is loaded with the IV.
- next  input  1  hash this block continuing from the current H.
- block  input  512  padded message block; word W0 = block[511:480], W15 = block[31:0].
- ready  output  1  high when idle and able to accept init/next.
- digest  output  160  {H0,H1,H2,H3,H4}, H0 in bits [159:128].
- digest_valid  output  1  high once digest holds the result of the last completed block.

Behaviour:
- Reset (async, reset_n=0):
  - H0..H4, a..e, round counter and W window all 0.
  - Control state IDLE; ready=1; digest_valid=0; digest=0.
- Control FSM has three states: IDLE, ROUNDS, DONE.
  - ready = (state==IDLE), derived combinationally from the state register.
- IDLE, accepting edge E0 (init or next sampled high):
  - If init: H0..H4 <= 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0, and a..e are loaded from these constants.
  - If next: a..e are loaded from the current H0..H4.
  - W window <= block; round counter <= 0; digest_valid <= 0; state -> ROUNDS.
  - If init and next are both high, init wins.
- ROUNDS, edges E1..E80: each performs round t=0..79.
  - T = rotl5(a) + f_t(b,c,d) + e + K_t + W_t (mod 2^32).
  - e<=d, d<=c, c<=rotl30(b), b<=a, a<=T.
  - f/K by round range:
    - t 0-19: Ch = (b&c)|(~b&d), K=5A827999.
    - t 20-39: Parity = b^c^d, K=6ED9EBA1.
    - t 40-59: Maj = (b&c)|(b&d)|(c&d), K=8F1BBCDC.
    - t 60-79: Parity, K=CA62C1D6.
- Message schedule:
  - 16-word sliding window.
  - W_t for t<16 comes from block.
  - For t>=16: W_t = rotl1(W_{t-3}^W_{t-8}^W_{t-14}^W_{t-16}), shifted into the window each round.
- Counter reaches 80 at E80; state -> DONE.
- DONE, edge E81:
  - Hi <= Hi + {a,b,c,d,e}i (mod 2^32).
  - digest_valid <= 1; state -> IDLE, so ready=1 after E81.
- Latency: ready is low for exactly 81 cycles after the accepting edge.
- init/next asserted while not IDLE are ignored; block is sampled only at the accepting edge and may change afterwards.
- digest is driven from the H registers at all times. It holds its value until the next DONE, or until an init overwrites it with the IV.
- A reset asserted mid-operation aborts the block immediately and returns all state to reset values.
- Holding init/next high in IDLE re-triggers a new block each time the FSM returns to IDLE.
- All additions are 32-bit wrap-around with no carry out.
- Internal observables:
  - H0_reg..H4_reg, a_reg..e_reg, round_ctr_reg (7 bits), sha1_ctrl_reg.
  - Control strobes: digest_init, digest_update, state_init, state_update, w_init, round_ctr_inc, round_ctr_rst, first_block, ready_flag.
  - Next-state values a_new..e_new, w, and f/k/t inside the state-logic process.

Test Plan:
- Reset, then check idle outputs -> ready=1, digest_valid=0, digest=0.
- init with block 746865717569636B62726F776E666F786A756D70736F7665727468656C617A79646F67746865717569636B62726F776E666F786A756D708000000000000001B8, one-cycle pulse -> ready low 81 cycles, then digest=58141f4f10dda66ff7efdf84217399e5ab6b963b, digest_valid=1.
- init with "abc" block 61626380 followed by zeros, last word 00000018 -> digest=a9993e364706816aba3e25717850c26c9cd0d89d.
- Two-block message:
  - init with block 6162636462636465636465666465666765666768666768696768696A68696A6B696A6B6C6A6B6C6D6B6C6D6E6C6D6E6F6D6E6F706E6F70718000000000000000 -> digest=f4286818c37b27ae0408f581846771484a566572.
  - then next with all-zero block whose last word is 000001C0 -> digest=84983e441c3bd26ebaae4aa1f95129e5e54670f1.
- Pulse init or next during ROUNDS, and change block mid-run -> result unchanged from the uninterrupted run, and no extra block is processed.
- Assert reset_n=0 at round ~40 -> ready=1, digest_valid=0, digest=0 immediately; a subsequent "abc" init yields the correct digest.
